// File: rtl/wave_capture_pkg.sv
// Shared constants for the zero-crossing triggered waveform capture block.
// Holds the FSM encodings, capture length, RAM address width and the offset-binary helper.
package wave_capture_pkg;

  localparam int SAMPLES_DEFAULT = 256;
  localparam int ADDR_W = 9;
  localparam logic [7:0] SAMPLE_OFFSET = 8'd128;

  localparam logic [1:0] ST_ARMED  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // Signed sample to unsigned offset-binary: top byte plus mid-scale.
  function automatic logic [7:0] to_offset_binary(input logic [15:0] sample);
    return sample[15:8] + SAMPLE_OFFSET;
  endfunction

endpackage

// File: rtl/wave_capture_trigger.sv
// Rising zero-crossing detector: remembers the previous strobed sample and flags
// a strobe whose sample is non-negative while the previous one was negative.
module wave_capture_trigger
  import wave_capture_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_strobe,
  input  logic [15:0] i_sample,
  output logic        o_trigger
);

  logic [15:0] r_prev_sample;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev_sample <= 16'd0;
    end else if (i_strobe) begin
      r_prev_sample <= i_sample;
    end
  end

  assign o_trigger = i_strobe & r_prev_sample[15] & ~i_sample[15];

endmodule

// File: rtl/wave_capture.sv
// Captures SAMPLES offset-binary samples after a rising zero crossing into the
// half of an external double-buffered RAM that the display is not reading.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_sample_ready,
  input  logic [15:0]       new_sample_in,
  input  logic              wave_display_idle,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_enable,
  output logic [7:0]        write_sample,
  output logic              read_index,
  output logic [1:0]        o_dbg_state
);

  localparam logic [8:0] LAST_IDX = 9'(SAMPLES - 1);
  // A one-sample capture is complete as soon as the trigger sample is written.
  localparam logic [1:0] ST_AFTER_TRIGGER = (SAMPLES == 1) ? ST_WAIT : ST_ACTIVE;

  logic [1:0]        r_state;
  logic [8:0]        r_count;
  logic              r_read_index;
  logic              r_write_enable;
  logic [ADDR_W-1:0] r_write_address;
  logic [7:0]        r_write_sample;
  logic              w_trigger;

  wave_capture_trigger u_trigger (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_strobe  (new_sample_ready),
    .i_sample  (new_sample_in),
    .o_trigger (w_trigger)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_ARMED;
      r_count         <= 9'd0;
      r_read_index    <= 1'b0;
      r_write_enable  <= 1'b0;
      r_write_address <= '0;
      r_write_sample  <= 8'd0;
    end else begin
      r_write_enable <= 1'b0;
      case (r_state)
        ST_ARMED: begin
          if (w_trigger) begin
            r_write_enable  <= 1'b1;
            r_write_address <= {~r_read_index, 8'd0};
            r_write_sample  <= to_offset_binary(new_sample_in);
            r_count         <= 9'd1;
            r_state         <= ST_AFTER_TRIGGER;
          end
        end
        ST_ACTIVE: begin
          if (new_sample_ready) begin
            r_write_enable  <= 1'b1;
            r_write_address <= {~r_read_index, r_count[7:0]};
            r_write_sample  <= to_offset_binary(new_sample_in);
            r_count         <= r_count + 9'd1;
            if (r_count == LAST_IDX) begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Swap halves only once the display is between frames.
          if (wave_display_idle) begin
            r_read_index <= ~r_read_index;
            r_count      <= 9'd0;
            r_state      <= ST_ARMED;
          end
        end
        default: begin
          r_state <= ST_ARMED;
          r_count <= 9'd0;
        end
      endcase
    end
  end

  assign write_enable  = r_write_enable;
  assign write_address = r_write_address;
  assign write_sample  = r_write_sample;
  assign read_index    = r_read_index;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: new_sample_ready  input  1  one-cycle strobe marking new_sample_in valid.
REQ-004 SHALL have port: new_sample_in  input  16  signed two's-complement audio sample.
REQ-005 SHALL have port: wave_display_idle  input  1  high while display is outside its active drawing region.
REQ-006 SHALL have port: write_address  output  9  sample RAM write address, {buffer bit, index[7:0]}.
REQ-007 SHALL have port: write_enable  output  1  sample RAM write strobe.
REQ-008 SHALL have port: write_sample  output  8  unsigned 8-bit sample to store.
REQ-009 SHALL have port: read_index  output  1  buffer half the display reads; capture always writes the other half.
REQ-010 SHALL use parameter: SAMPLES, default 256, samples per capture.

Function
REQ-011 SHALL implement states ARMED, ACTIVE, WAIT.
REQ-012 SHALL keep prev_sample (16 bit), loaded with new_sample_in on every new_sample_ready in every state.
REQ-013 In ARMED, SHALL detect a trigger when new_sample_ready=1, prev_sample[15]=1 and new_sample_in[15]=0 (rising zero crossing, 0 counts non-negative).
REQ-014 On trigger, SHALL write the triggering sample at index 0, set count=1, go ACTIVE.
REQ-015 In ACTIVE, SHALL write each strobed sample at index count and increment count; after index SAMPLES-1 is written, go WAIT.
REQ-016 SHALL ignore new_sample_ready for writing in ARMED (non-trigger) and WAIT.
REQ-017 In WAIT, when wave_display_idle=1, SHALL toggle read_index, clear count, go ARMED in one cycle.
REQ-018 In WAIT, a new_sample_ready coinciding with wave_display_idle SHALL still be ignored for writing and trigger, but SHALL update prev_sample.
REQ-019 write_enable, write_address, write_sample SHALL be registered: asserted exactly 1 cycle after the accepting strobe, for exactly 1 cycle.
REQ-020 write_address SHALL equal {~read_index, index[7:0]} using read_index at the time of acceptance.
REQ-021 write_sample SHALL equal new_sample_in[15:8] + 8'd128, modulo 256 (signed to offset binary).
REQ-022 read_index SHALL change only in WAIT->ARMED transition; never while a capture is in progress.
REQ-023 count SHALL be 9 bits wide internally so SAMPLES-1 terminal detection does not wrap prematurely.
REQ-024 When write_enable=0, write_address and write_sample SHALL hold last values.

Reset
REQ-025 On reset=1 at a clock edge: state=ARMED, count=0, prev_sample=0, read_index=0, write_enable=0, write_address=0, write_sample=0.
REQ-026 Reset asserted mid-capture SHALL abandon the capture; partial buffer contents are don't-care, no further write_enable until a new trigger.
REQ-027 Reset SHALL dominate all other inputs in the same cycle.

Structure
REQ-028 Shared package SHALL hold state encodings (ARMED, ACTIVE, WAIT), SAMPLES default 256, offset constant 8'd128, RAM address width 9.
REQ-029 Rising-zero-crossing detection SHALL be a sub-module named wave_capture_trigger (prev_sample register plus compare, output trigger).
REQ-030 Sample RAM is external; block SHALL contain no memory.

Verification
REQ-031 Reset, feed samples -100,-1,0,5 -> trigger on 0; write at addr 9'h100 data 8'h80, one cycle after strobe.
REQ-032 Feed 300 strobes after trigger (ramp 0x0000,0x0100,...) -> exactly 256 writes, addresses 0x100..0x1FF, data 0x80,0x81,...; no writes after.
REQ-033 In WAIT, hold wave_display_idle=0 for 100 cycles then 1 for 1 cycle -> read_index 0->1 next cycle; next capture writes 0x000..0x0FF.
REQ-034 Feed all-positive samples 1000,2000 from reset -> no trigger, write_enable stays 0; then -1 then 1 -> trigger.
REQ-035 Assert reset at capture index 100 -> write_enable 0 next cycle, state ARMED, read_index 0; crossing -5,3 restarts at addr 0x100.
REQ-036 Sample 0x7FFF -> write_sample 0xFF; sample 0x8000 -> 0x00.
